pc_stack_unit: RTL

Parametrised program-counter and hardware return-stack unit for the 14-bit-instruction CPU core. Generalises the existing counter with configurable PC width, jump-field width, page bits and stack depth. Adds conditional skip, circular stack with sticky overflow/underflow flags, and an occupancy count. The core's instruction-cycle phase logic strobes it once per instruction via `adv`; its `pc` output addresses instruction memory.

---
 rtl/pc_stack_unit.sv | 74 +++++++
 1 files changed

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with circular hardware return stack and sticky overflow/underflow flags
module pc_stack_unit #(
    parameter int PC_WIDTH = 13,
    parameter int JUMP_WIDTH = 11,
    parameter int STACK_DEPTH = 8,
    localparam int PAGE_WIDTH = PC_WIDTH - JUMP_WIDTH,
    localparam int SW = $clog2(STACK_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adv,
    input  logic [2:0]            op,
    input  logic                  cond,
    input  logic [JUMP_WIDTH-1:0] target,
    input  logic [PAGE_WIDTH-1:0] page,
    input  logic                  clr_flags,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [SW-1:0]         sp,
    output logic [SW:0]           stk_count,
    output logic                  stk_ovf,
    output logic                  stk_unf
);
    localparam logic [2:0] OP_GOTO = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_RET  = 3'b011;
    localparam logic [2:0] OP_SKIP = 3'b100;
    localparam logic [2:0] OP_HOLD = 3'b101;

    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
    logic [PC_WIDTH-1:0] pc_next, pc_inc, pc_jump;
    logic [SW-1:0]       sp_dec;
    logic                push, pop, full, empty;

    assign pc_inc  = pc + PC_WIDTH'(1);
    assign pc_jump = {page, target};
    assign sp_dec  = sp - SW'(1);
    assign push    = adv && op == OP_CALL;
    assign pop     = adv && op == OP_RET;
    assign full    = stk_count == (SW+1)'(STACK_DEPTH);
    assign empty   = stk_count == '0;

    // next pc selection; reserved opcodes fall through to sequential increment
    always_comb begin
        pc_next = (op == OP_GOTO || op == OP_CALL) ? pc_jump :
                  (op == OP_RET)                   ? stack[sp_dec] :
                  (op == OP_HOLD)                  ? pc :
                  (op == OP_SKIP && cond)          ? pc + PC_WIDTH'(2) : pc_inc;
    end

    // pc, stack and flag state; a full stack overwrites its oldest entry on push
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= '0;
            sp        <= '0;
            stk_count <= '0;
            stk_ovf   <= 1'b0;
            stk_unf   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else begin
            if (adv) pc <= pc_next;
            if (push) begin
                stack[sp] <= pc_inc;
                sp        <= sp + SW'(1);
                if (!full) stk_count <= stk_count + (SW+1)'(1);
            end
            if (pop) begin
                sp <= sp_dec;
                if (!empty) stk_count <= stk_count - (SW+1)'(1);
            end
            stk_ovf <= (push && full) || (stk_ovf && !clr_flags);
            stk_unf <= (pop && empty) || (stk_unf && !clr_flags);
        end
    end
endmodule
